// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
//   Paces DAC sample delivery at a programmable rate, arbitrates between the
//   baseband stream and a static test code, and soft-ramps the DAC code
//   between zero and mid-scale on enable/disable. Randomisation is gated so
//   it is only active while streaming.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   en_i             transmit request (level)
//   rate_div_i       sample period = rate_div_i + 1 clocks
//   randomise_req_i  request thermometer-element randomisation
//   test_en_i        select test_code_i instead of the stream
//   test_code_i      static test code
//   data_valid_i     stream sample valid
//   data_i           stream sample, offset binary
//   data_ready_o     stream accept strobe (combinational)
//   dac_code_o       code to the DAC interface
//   dac_en_o         DAC enable
//   randomise_en_o   randomisation enable to the DAC interface
//   underflow_o      one-cycle underflow pulse
//   underflow_cnt_o  saturating underflow count
//   state_o          0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
module dac_sample_scheduler #(
  parameter int unsigned INPUT_WIDTH = 10,
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned RAMP_STEP   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [DIV_WIDTH-1:0]   rate_div_i,
  input  logic                   randomise_req_i,
  input  logic                   test_en_i,
  input  logic [INPUT_WIDTH-1:0] test_code_i,
  input  logic                   data_valid_i,
  input  logic [INPUT_WIDTH-1:0] data_i,
  output logic                   data_ready_o,
  output logic [INPUT_WIDTH-1:0] dac_code_o,
  output logic                   dac_en_o,
  output logic                   randomise_en_o,
  output logic                   underflow_o,
  output logic [7:0]             underflow_cnt_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [INPUT_WIDTH-1:0] MID  = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
  localparam logic [INPUT_WIDTH-1:0] STEP = INPUT_WIDTH'(RAMP_STEP);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DIV_WIDTH-1:0]   r_div;
  logic                   w_tick;
  logic [INPUT_WIDTH-1:0] r_code;
  logic [INPUT_WIDTH-1:0] w_code_next;
  logic                   r_dac_en;
  logic                   r_rand_en;
  logic                   r_underflow;
  logic [7:0]             r_uf_cnt;
  logic                   w_underflow;
  logic                   w_uf_clear;
  logic                   w_ready;

  logic [INPUT_WIDTH-1:0] w_mid_dist;
  logic [INPUT_WIDTH-1:0] w_up_step;
  logic [INPUT_WIDTH-1:0] w_toward_mid;
  logic [INPUT_WIDTH-1:0] w_down_step;
  logic [INPUT_WIDTH-1:0] w_toward_zero;

  assign w_tick = (r_state != IDLE) && (r_div >= rate_div_i);

  // Ramp arithmetic: clamp each step so the code lands exactly on its target.
  always_comb begin
    w_mid_dist    = (r_code > MID) ? (r_code - MID) : (MID - r_code);
    w_up_step     = (w_mid_dist < STEP) ? w_mid_dist : STEP;
    w_toward_mid  = (r_code > MID) ? (r_code - w_up_step) : (r_code + w_up_step);
    w_down_step   = (r_code < STEP) ? r_code : STEP;
    w_toward_zero = r_code - w_down_step;
  end

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_underflow  = 1'b0;
    w_uf_clear   = 1'b0;
    w_ready      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en_i) begin
          w_state_next = RAMP_UP;
          w_uf_clear   = 1'b1;
        end
      end
      RAMP_UP: begin
        if (!en_i) begin
          w_state_next = RAMP_DOWN;
        end else if (w_tick) begin
          w_code_next = w_toward_mid;
          if (w_toward_mid == MID) w_state_next = RUN;
        end
      end
      RUN: begin
        // The strobe is suppressed on the edge that leaves RUN so that the
        // handshake never reports a transfer that did not take place.
        if (!en_i) begin
          w_state_next = RAMP_DOWN;
        end else if (w_tick) begin
          if (test_en_i) begin
            w_code_next = test_code_i;
          end else begin
            w_ready = 1'b1;
            if (data_valid_i) begin
              w_code_next = data_i;
            end else begin
              w_code_next = MID;
              w_underflow = 1'b1;
            end
          end
        end
      end
      RAMP_DOWN: begin
        if (en_i) begin
          w_state_next = RAMP_UP;
        end else if (w_tick) begin
          w_code_next = w_toward_zero;
          if (w_toward_zero == '0) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_code      <= '0;
      r_dac_en    <= 1'b0;
      r_rand_en   <= 1'b0;
      r_underflow <= 1'b0;
      r_uf_cnt    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_code      <= w_code_next;
      r_dac_en    <= (w_state_next != IDLE);
      r_rand_en   <= (w_state_next == RUN) && randomise_req_i;
      r_underflow <= w_underflow;
      if (r_state == IDLE || w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DIV_WIDTH'(1);
      end
      if (w_uf_clear) begin
        r_uf_cnt <= '0;
      end else if (w_underflow && (r_uf_cnt != '1)) begin
        r_uf_cnt <= r_uf_cnt + 8'd1;
      end
    end
  end

  assign data_ready_o    = w_ready;
  assign dac_code_o      = r_code;
  assign dac_en_o        = r_dac_en;
  assign randomise_en_o  = r_rand_en;
  assign underflow_o     = r_underflow;
  assign underflow_cnt_o = r_uf_cnt;
  assign state_o         = r_state;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
module tb_dac_sample_scheduler;

  localparam int W    = 10;
  localparam int MID  = 512;
  localparam int STEP = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic [7:0]    rate_div_i;
  logic          randomise_req_i;
  logic          test_en_i;
  logic [W-1:0]  test_code_i;
  logic          data_valid_i;
  logic [W-1:0]  data_i;
  logic          data_ready_o;
  logic [W-1:0]  dac_code_o;
  logic          dac_en_o;
  logic          randomise_en_o;
  logic          underflow_o;
  logic [7:0]    underflow_cnt_o;
  logic [1:0]    state_o;

  dac_sample_scheduler #(
    .INPUT_WIDTH(W),
    .DIV_WIDTH  (8),
    .RAMP_STEP  (STEP)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .rate_div_i     (rate_div_i),
    .randomise_req_i(randomise_req_i),
    .test_en_i      (test_en_i),
    .test_code_i    (test_code_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .data_ready_o   (data_ready_o),
    .dac_code_o     (dac_code_o),
    .dac_en_o       (dac_en_o),
    .randomise_en_o (randomise_en_o),
    .underflow_o    (underflow_o),
    .underflow_cnt_o(underflow_cnt_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: state as 0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN.
  int m_state, m_code, m_div, m_en, m_rand, m_uf, m_cnt;
  int s_next;       // next stream sample value to present
  int ready_seen;   // DUT data_ready_o pulses counted by cyc()

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_code = 0; m_div = 0; m_en = 0; m_rand = 0; m_uf = 0; m_cnt = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_code"},  dac_code_o, 0);
    chk({tag, "_en"},    dac_en_o, 0);
    chk({tag, "_rand"},  randomise_en_o, 0);
    chk({tag, "_uf"},    underflow_o, 0);
    chk({tag, "_cnt"},   underflow_cnt_o, 0);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_ready"}, data_ready_o, 0);
  endtask

  // One clock cycle: entered shortly after a rising edge with inputs set.
  task automatic cyc();
    bit tick, rdy, uf, clr, xfer;
    int ns, nc;
    data_i = W'(s_next);
    #3;
    tick = (m_state != 0) && (m_div >= int'(rate_div_i));
    rdy  = tick && (m_state == 2) && en_i && !test_en_i;
    chk("data_ready", data_ready_o, rdy);
    if (data_ready_o === 1'b1) ready_seen++;
    xfer = rdy && data_valid_i;
    ns = m_state; nc = m_code; uf = 0; clr = 0;
    case (m_state)
      0: if (en_i) begin ns = 1; clr = 1; end
      1: begin
        if (!en_i) ns = 3;
        else if (tick) begin
          if (m_code < MID) nc = (m_code + STEP > MID) ? MID : m_code + STEP;
          else              nc = (m_code - STEP < MID) ? MID : m_code - STEP;
          if (nc == MID) ns = 2;
        end
      end
      2: begin
        if (!en_i) ns = 3;
        else if (tick) begin
          if (test_en_i)         nc = int'(test_code_i);
          else if (data_valid_i) nc = int'(data_i);
          else begin nc = MID; uf = 1; end
        end
      end
      default: begin
        if (en_i) ns = 1;
        else if (tick) begin
          nc = (m_code < STEP) ? 0 : m_code - STEP;
          if (nc == 0) ns = 0;
        end
      end
    endcase
    m_rand = (ns == 2) ? int'(randomise_req_i) : 0;
    m_div  = (m_state == 0 || tick) ? 0 : m_div + 1;
    m_en   = (ns != 0);
    m_uf   = uf;
    if (clr) m_cnt = 0;
    else if (uf && m_cnt < 255) m_cnt++;
    m_state = ns;
    m_code  = nc;
    @(posedge clk_i);
    #1;
    if (xfer) s_next++;
    chk("dac_code",  dac_code_o, m_code);
    chk("dac_en",    dac_en_o, m_en);
    chk("rand_en",   randomise_en_o, m_rand);
    chk("underflow", underflow_o, m_uf);
    chk("uf_count",  underflow_cnt_o, m_cnt);
    chk("state",     state_o, m_state);
  endtask

  initial begin
    int n;
    rst_ni = 1'b0; en_i = 1'b0; rate_div_i = '0; randomise_req_i = 1'b0;
    test_en_i = 1'b0; test_code_i = '0; data_valid_i = 1'b0; data_i = '0;
    s_next = 0; ready_seen = 0;
    model_reset();
    #12;
    chk_reset_values("reset");
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Ramp from zero to mid-scale at one tick per clock.
    en_i = 1'b1; randomise_req_i = 1'b1;
    n = 0;
    while (state_o !== 2'd2 && n < 300) begin cyc(); n++; end
    chk("ramp_up_cycles", n, 129);
    chk("ramp_up_code", dac_code_o, MID);

    // Streaming with valid held high, one sample per 4-clock period.
    rate_div_i = 8'd3; data_valid_i = 1'b1; s_next = 'h100; ready_seen = 0;
    for (int i = 0; i < 40; i++) cyc();
    chk("stream_pulses", ready_seen, 10);

    // Single underflow, then recovery.
    data_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("uf_single", underflow_cnt_o, 1);
    data_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) cyc();

    // Sustained underflow saturates the counter.
    rate_div_i = 8'd0; data_valid_i = 1'b0;
    for (int i = 0; i < 300; i++) cyc();
    chk("uf_saturated", underflow_cnt_o, 255);

    // Test code overrides the stream; no strobes, no underflows.
    rate_div_i = 8'd2; data_valid_i = 1'b1; test_en_i = 1'b1; test_code_i = 10'h3FF;
    ready_seen = 0;
    for (int i = 0; i < 9; i++) cyc();
    chk("test_no_ready", ready_seen, 0);
    chk("test_code", dac_code_o, 'h3FF);

    // Ramp down from full scale to zero.
    rate_div_i = 8'($urandom_range(0, 2));
    en_i = 1'b0;
    n = 0;
    while (state_o !== 2'd0 && n < 800) begin cyc(); n++; end
    chk("ramp_down_idle", state_o, 0);
    chk("ramp_down_en", dac_en_o, 0);

    // Re-enter RUN, load 700, bounce through RAMP_DOWN back up to mid-scale.
    rate_div_i = 8'd0; en_i = 1'b1; test_code_i = 10'd700;
    n = 0;
    while (state_o !== 2'd2 && n < 300) begin cyc(); n++; end
    cyc();
    chk("code_700", dac_code_o, 700);
    en_i = 1'b0; cyc();
    en_i = 1'b1;
    n = 0;
    while (state_o !== 2'd2 && n < 100) begin cyc(); n++; end
    chk("ramp_from_700_cycles", n, 48);

    // Randomised traffic, including live rate changes and ramp reversals.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)  en_i = ~en_i;
      if ($urandom_range(0, 99) < 5)  rate_div_i = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 2)  test_en_i = ~test_en_i;
      if ($urandom_range(0, 99) < 10) randomise_req_i = ~randomise_req_i;
      test_code_i  = W'($urandom);
      data_valid_i = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Asynchronous reset mid-RUN with outputs non-zero.
    en_i = 1'b1; rate_div_i = 8'd0; test_en_i = 1'b0; randomise_req_i = 1'b1;
    data_valid_i = 1'b1;
    n = 0;
    while (state_o !== 2'd2 && n < 1000) begin cyc(); n++; end
    chk("pre_reset_run", state_o, 2);
    data_valid_i = 1'b0;
    cyc(); cyc();
    chk("pre_reset_rand", randomise_en_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_values("async_reset");
    en_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
